// File: rtl/bus_timer_if.sv
// Data-bus connection between the pipeline initiator and the bus timer.
// The interrupt line is carried here as well.
interface bus_timer_if;
  logic [31:0] addr;
  logic [3:0]  byteen;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq;

  modport master (output addr, output byteen, output wdata, input rdata, input irq);
  modport slave  (input addr, input byteen, input wdata, output rdata, output irq);
endinterface

// File: rtl/bus_timer.sv
// Memory-mapped down-counter with one-shot and auto-reload modes.
// CTRL/PRESET/COUNT sit in a three-word window at BASE_ADDR.
module bus_timer #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_7F00
) (
  input  logic       clk,
  input  logic       reset,
  bus_timer_if.slave bus
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned WOFF_W = 30;
  localparam int unsigned CTRL_W = 4;
  localparam int unsigned NUM_REGS = 3;

  localparam logic [1:0] OFF_CTRL   = 2'd0;
  localparam logic [1:0] OFF_PRESET = 2'd1;
  localparam logic [1:0] OFF_COUNT  = 2'd2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CNT  = 2'd2,
    INT  = 2'd3
  } state_t;

  state_t              state;
  logic [CTRL_W-1:0]   ctrl;
  logic [DATA_W-1:0]   preset;
  logic [DATA_W-1:0]   count;
  logic                irq_flag;
  logic                irq_pulse;

  logic [WOFF_W-1:0]   word_off;
  logic                sel;
  logic                wr;
  logic                wr_ctrl;
  logic                wr_preset;
  logic                ctrl_en;
  logic                ctrl_im;
  logic                auto_reload;
  logic                unused_addr_lsb;

  // Byte-granular register update from lane-replicated write data.
  function automatic logic [DATA_W-1:0] merge_lanes(input logic [DATA_W-1:0] old_val,
                                                    input logic [DATA_W-1:0] wd,
                                                    input logic [3:0]        be);
    logic [DATA_W-1:0] r;
    r = old_val;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) r[8*i +: 8] = wd[8*i +: 8];
    end
    return r;
  endfunction

  assign word_off    = bus.addr[31:2] - BASE_ADDR[31:2];
  assign sel         = word_off < WOFF_W'(NUM_REGS);
  assign wr          = sel && (bus.byteen != 4'b0000);
  assign wr_ctrl     = wr && (word_off[1:0] == OFF_CTRL);
  assign wr_preset   = wr && (word_off[1:0] == OFF_PRESET);
  assign unused_addr_lsb = ^bus.addr[1:0];

  assign ctrl_en     = ctrl[0];
  assign auto_reload = (ctrl[2:1] == 2'b01);
  assign ctrl_im     = ctrl[3];

  // Combinational read mux; COUNT is exposed read-only.
  always_comb begin
    bus.rdata = '0;
    if (sel) begin
      case (word_off[1:0])
        OFF_CTRL:   bus.rdata = {{(DATA_W-CTRL_W){1'b0}}, ctrl};
        OFF_PRESET: bus.rdata = preset;
        OFF_COUNT:  bus.rdata = count;
        default:    bus.rdata = '0;
      endcase
    end
  end

  assign bus.irq = ctrl_im & irq_flag;

  // Counter FSM; bus writes are applied last so they override FSM updates.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      ctrl      <= '0;
      preset    <= '0;
      count     <= '0;
      irq_flag  <= 1'b0;
      irq_pulse <= 1'b0;
    end else begin
      irq_pulse <= 1'b0;
      if (irq_pulse) irq_flag <= 1'b0;

      case (state)
        IDLE: begin
          if (ctrl_en) state <= LOAD;
        end
        LOAD: begin
          count <= preset;
          state <= CNT;
        end
        CNT: begin
          if (!ctrl_en)              state <= IDLE;
          else if (count == '0)      state <= INT;
          else                       count <= count - DATA_W'(1);
        end
        INT: begin
          irq_flag <= 1'b1;
          if (auto_reload) begin
            irq_pulse <= 1'b1;
            state     <= LOAD;
          end else begin
            ctrl[0]   <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      if (wr_ctrl) begin
        irq_flag  <= 1'b0;
        irq_pulse <= 1'b0;
        if (bus.byteen[0]) ctrl <= bus.wdata[CTRL_W-1:0];
      end
      if (wr_preset) preset <= merge_lanes(preset, bus.wdata, bus.byteen);
    end
  end

endmodule

// File: tb/tb_bus_timer.sv
// Directed self-checking bench for bus_timer.
module tb_bus_timer;

  localparam logic [31:0] A_CTRL   = 32'h0000_7F00;
  localparam logic [31:0] A_PRESET = 32'h0000_7F04;
  localparam logic [31:0] A_COUNT  = 32'h0000_7F08;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  bus_timer_if bus ();

  bus_timer #(.BASE_ADDR(32'h0000_7F00)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic bus_write(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
    @(negedge clk);
    bus.addr   = a;
    bus.byteen = be;
    bus.wdata  = d;
    @(posedge clk);
    #1;
    bus.byteen = 4'b0000;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    bus.addr   = a;
    bus.byteen = 4'b0000;
    #1;
    d = bus.rdata;
  endtask

  // Reset with a concurrent PRESET write that must be discarded.
  task automatic do_reset();
    @(negedge clk);
    reset      = 1'b0;
    bus.addr   = A_PRESET;
    bus.byteen = 4'hF;
    bus.wdata  = 32'h0000_0055;
    @(posedge clk);
    #1;
    reset      = 1'b1;
    bus.byteen = 4'b0000;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    do_reset();
    bus_read(A_CTRL, d);
    n_checks++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL reset_ctrl: got %h expected %h", d, 32'h0); end
    bus_read(A_PRESET, d);
    n_checks++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL reset_preset: got %h expected %h", d, 32'h0); end
    bus_read(A_COUNT, d);
    n_checks++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL reset_count: got %h expected %h", d, 32'h0); end
    n_checks++;
    if (bus.irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq: got %b expected 0", bus.irq); end
  endtask

  task automatic test_one_shot();
    logic [31:0] d;
    logic [31:0] exp_cnt;
    logic        exp_irq;
    do_reset();
    bus_write(A_PRESET, 4'hF, 32'd3);
    bus_write(A_CTRL, 4'hF, 32'h9);
    for (int k = 1; k <= 7; k++) begin
      @(posedge clk); #1;
      exp_cnt = (k >= 2 && k <= 5) ? 32'(5 - k) : 32'd0;
      exp_irq = (k == 7);
      bus_read(A_COUNT, d);
      n_checks++;
      if (d !== exp_cnt) begin n_fail++; $display("FAIL oneshot_count[%0d]: got %h expected %h", k, d, exp_cnt); end
      n_checks++;
      if (bus.irq !== exp_irq) begin n_fail++; $display("FAIL oneshot_irq[%0d]: got %b expected %b", k, bus.irq, exp_irq); end
    end
    bus_read(A_CTRL, d);
    n_checks++;
    if (d !== 32'h8) begin n_fail++; $display("FAIL oneshot_ctrl: got %h expected %h", d, 32'h8); end
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (bus.irq !== 1'b1) begin n_fail++; $display("FAIL oneshot_irq_sticky: got %b expected 1", bus.irq); end
    bus_write(A_CTRL, 4'hF, 32'h8);
    n_checks++;
    if (bus.irq !== 1'b0) begin n_fail++; $display("FAIL oneshot_irq_clear: got %b expected 0", bus.irq); end
  endtask

  task automatic test_auto_reload();
    logic [31:0] d;
    logic [31:0] exp_cnt;
    logic        exp_irq;
    int          p;
    do_reset();
    bus_write(A_PRESET, 4'hF, 32'd2);
    bus_write(A_CTRL, 4'hF, 32'hB);
    for (int k = 1; k <= 17; k++) begin
      @(posedge clk); #1;
      p = (k >= 2) ? (k - 2) % 5 : -1;
      exp_cnt = (p == 0) ? 32'd2 : (p == 1) ? 32'd1 : 32'd0;
      exp_irq = (p == 4);
      bus_read(A_COUNT, d);
      n_checks++;
      if (d !== exp_cnt) begin n_fail++; $display("FAIL auto_count[%0d]: got %h expected %h", k, d, exp_cnt); end
      n_checks++;
      if (bus.irq !== exp_irq) begin n_fail++; $display("FAIL auto_irq[%0d]: got %b expected %b", k, bus.irq, exp_irq); end
    end
    bus_read(A_CTRL, d);
    n_checks++;
    if (d !== 32'hB) begin n_fail++; $display("FAIL auto_ctrl_en_kept: got %h expected %h", d, 32'hB); end
    bus_write(A_CTRL, 4'hF, 32'h0);
  endtask

  task automatic test_byte_write();
    logic [31:0] d;
    do_reset();
    bus_write(A_PRESET, 4'hF, 32'h1234_5678);
    bus_write(A_PRESET, 4'b0010, 32'hAAAA_AAAA);
    bus_read(A_PRESET, d);
    n_checks++;
    if (d !== 32'h1234_AA78) begin n_fail++; $display("FAIL byte_lane1: got %h expected %h", d, 32'h1234_AA78); end
    bus_write(A_PRESET, 4'b1001, 32'hCDCD_CDCD);
    bus_read(A_PRESET, d);
    n_checks++;
    if (d !== 32'hCD34_AACD) begin n_fail++; $display("FAIL byte_lane30: got %h expected %h", d, 32'hCD34_AACD); end
    bus_write(A_CTRL, 4'b1110, 32'hFFFF_FFFF);
    bus_read(A_CTRL, d);
    n_checks++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL ctrl_upper_lanes: got %h expected %h", d, 32'h0); end
  endtask

  task automatic test_mid_count_disable();
    logic [31:0] d;
    do_reset();
    bus_write(A_PRESET, 4'hF, 32'd8);
    bus_write(A_CTRL, 4'hF, 32'h1);
    repeat (4) @(posedge clk);
    bus_write(A_CTRL, 4'hF, 32'h8);
    bus_read(A_COUNT, d);
    n_checks++;
    if (d !== 32'd5) begin n_fail++; $display("FAIL disable_count_at_stop: got %h expected %h", d, 32'd5); end
    repeat (15) @(posedge clk);
    #1;
    bus_read(A_COUNT, d);
    n_checks++;
    if (d !== 32'd5) begin n_fail++; $display("FAIL disable_count_held: got %h expected %h", d, 32'd5); end
    n_checks++;
    if (bus.irq !== 1'b0) begin n_fail++; $display("FAIL disable_no_irq: got %b expected 0", bus.irq); end
    bus_write(A_COUNT, 4'hF, 32'hFFFF_FFFF);
    bus_read(A_COUNT, d);
    n_checks++;
    if (d !== 32'd5) begin n_fail++; $display("FAIL count_readonly: got %h expected %h", d, 32'd5); end
  endtask

  task automatic test_preset_during_cnt();
    logic [31:0] d;
    do_reset();
    bus_write(A_PRESET, 4'hF, 32'd4);
    bus_write(A_CTRL, 4'hF, 32'h1);
    repeat (3) @(posedge clk);
    bus_write(A_PRESET, 4'hF, 32'd9);
    bus_read(A_COUNT, d);
    n_checks++;
    if (d !== 32'd2) begin n_fail++; $display("FAIL preset_in_cnt_count: got %h expected %h", d, 32'd2); end
    repeat (4) @(posedge clk);
    #1;
    bus_read(A_CTRL, d);
    n_checks++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL preset_in_cnt_en_cleared: got %h expected %h", d, 32'h0); end
    n_checks++;
    if (bus.irq !== 1'b0) begin n_fail++; $display("FAIL preset_in_cnt_masked: got %b expected 0", bus.irq); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    do_reset();
    bus_write(A_PRESET, 4'hF, 32'd0);
    bus_write(A_CTRL, 4'hF, 32'h9);
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (bus.irq !== 1'b0) begin n_fail++; $display("FAIL zero_preset_irq_early: got %b expected 0", bus.irq); end
    bus_write(A_CTRL, 4'hF, 32'h9);
    n_checks++;
    if (bus.irq !== 1'b0) begin n_fail++; $display("FAIL collide_irq_cleared: got %b expected 0", bus.irq); end
    bus_read(A_CTRL, d);
    n_checks++;
    if (d !== 32'h9) begin n_fail++; $display("FAIL collide_en_kept: got %h expected %h", d, 32'h9); end
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (bus.irq !== 1'b0) begin n_fail++; $display("FAIL restart_irq_early: got %b expected 0", bus.irq); end
    @(posedge clk); #1;
    n_checks++;
    if (bus.irq !== 1'b1) begin n_fail++; $display("FAIL restart_irq: got %b expected 1", bus.irq); end
    bus_write(A_CTRL, 4'hF, 32'h0);
  endtask

  task automatic test_reset_mid_count();
    logic [31:0] d;
    do_reset();
    bus_write(A_PRESET, 4'hF, 32'd10);
    bus_write(A_CTRL, 4'hF, 32'h9);
    repeat (5) @(posedge clk);
    do_reset();
    bus_read(A_CTRL, d);
    n_checks++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL midreset_ctrl: got %h expected %h", d, 32'h0); end
    bus_read(A_PRESET, d);
    n_checks++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL midreset_preset: got %h expected %h", d, 32'h0); end
    bus_read(A_COUNT, d);
    n_checks++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL midreset_count: got %h expected %h", d, 32'h0); end
    repeat (20) @(posedge clk);
    #1;
    n_checks++;
    if (bus.irq !== 1'b0) begin n_fail++; $display("FAIL midreset_no_irq: got %b expected 0", bus.irq); end
  endtask

  task automatic test_out_of_window();
    logic [31:0] d;
    do_reset();
    bus_write(A_PRESET, 4'hF, 32'h0000_00A5);
    bus_write(32'h0000_7F0C, 4'hF, 32'hFFFF_FFFF);
    bus_write(32'h0000_0000, 4'hF, 32'hFFFF_FFFF);
    bus_read(32'h0000_7F0C, d);
    n_checks++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL oow_read_7f0c: got %h expected %h", d, 32'h0); end
    bus_read(32'h0000_0000, d);
    n_checks++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL oow_read_0: got %h expected %h", d, 32'h0); end
    bus_read(A_CTRL, d);
    n_checks++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL oow_ctrl: got %h expected %h", d, 32'h0); end
    bus_read(A_PRESET, d);
    n_checks++;
    if (d !== 32'h0000_00A5) begin n_fail++; $display("FAIL oow_preset: got %h expected %h", d, 32'h0000_00A5); end
    bus_read(32'h0000_7F06, d);
    n_checks++;
    if (d !== 32'h0000_00A5) begin n_fail++; $display("FAIL addr_lsb_ignored: got %h expected %h", d, 32'h0000_00A5); end
  endtask

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    reset      = 1'b0;
    bus.addr   = 32'h0;
    bus.byteen = 4'b0000;
    bus.wdata  = 32'h0;
    test_reset();
    test_one_shot();
    test_auto_reload();
    test_byte_write();
    test_mid_count_disable();
    test_preset_during_cnt();
    test_back_to_back();
    test_reset_mid_count();
    test_out_of_window();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bus_timer.md
BUS_TIMER -- requirements
Module: bus_timer

Interface
REQ-001 Parameter BASE_ADDR, default 32'h0000_7F00, word-aligned base of the 12-byte register window.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-low reset; registers clear on a rising clk edge when reset==0.
REQ-004 addr  input  32  bus byte address from the pipeline data-bus initiator.
REQ-005 byteen  input  4  byte write enables; 4'b0000 denotes a read or idle cycle.
REQ-006 wdata  input  32  write data, already lane-replicated by the initiator for halfword/byte stores.
REQ-007 rdata  output  32  read data for the addressed register.
REQ-008 irq  output  1  interrupt request, routed to one bit of the CPU HWInt vector.

Function
REQ-009 Window decode: sel = (addr[31:2] - BASE_ADDR[31:2]) < 3; addr[1:0] ignored; offset 0x0 CTRL, 0x4 PRESET, 0x8 COUNT.
REQ-010 CTRL layout: bit0 EN, bits2:1 MODE (00 one-shot, 01 auto-reload, 1x treated as 00), bit3 IM (interrupt mask, 1 = enabled); bits31:4 read as 0, write ignored.
REQ-011 Writes: when sel and byteen!=0, each byte lane i with byteen[i]=1 replaces byte i of the addressed register; other bytes unchanged.
REQ-012 COUNT is read-only; bus writes to offset 0x8 have no effect.
REQ-013 Reads are combinational: rdata = addressed register's current value when sel, else 32'h0.
REQ-014 FSM states IDLE, LOAD, CNT, INT; state register 2 bits.
REQ-015 IDLE: if EN==1 go LOAD next cycle; else stay; COUNT holds.
REQ-016 LOAD: COUNT <= PRESET; go CNT.
REQ-017 CNT: if EN==0 go IDLE with COUNT held; else if COUNT==0 go INT; else COUNT <= COUNT-1.
REQ-018 INT, MODE 00: irq_flag <= 1, EN <= 0, go IDLE; irq_flag remains set until cleared by REQ-020.
REQ-019 INT, MODE 01: irq_flag asserted for exactly this one cycle, go LOAD; no EN change.
REQ-020 Any bus write to CTRL clears irq_flag in the same edge.
REQ-021 irq = IM & irq_flag, combinational from registered state.
REQ-022 Latency: EN written 1 at edge T with PRESET=N gives LOAD at T+1, COUNT=N after T+2, COUNT=0 after T+2+N, INT state during cycle T+3+N, irq (MODE 00) visible from edge T+4+N.
REQ-023 Simultaneous bus write to CTRL and FSM update of EN/irq_flag in INT: bus write wins for EN; irq_flag is cleared.
REQ-024 PRESET writes while in CNT do not alter COUNT until the next LOAD.
REQ-025 PRESET=0: CNT sees COUNT==0 immediately and goes INT on the next cycle.
REQ-026 COUNT decrement never wraps below 0.

Reset
REQ-027 On reset==0 at a clock edge: CTRL=0, PRESET=0, COUNT=0, irq_flag=0, state=IDLE; hence rdata for any valid offset = 0 and irq=0 the cycle after.
REQ-028 Reset asserted mid-count aborts counting; no irq is generated for the aborted period.
REQ-029 Bus writes in the same cycle as reset==0 are discarded.

Verification
REQ-030 Reset then read 0x7F00/0x7F04/0x7F08 -> rdata 0 each; irq=0.
REQ-031 Write PRESET=3, CTRL=32'h9 (EN, one-shot, IM) -> COUNT reads 3,2,1,0 on successive cycles after LOAD; irq=1 from REQ-022 edge; CTRL reads 32'h8; write CTRL=32'h8 -> irq=0 next cycle.
REQ-032 PRESET=2, CTRL=32'hB (auto-reload) -> irq 1-cycle pulse every 5 cycles, COUNT sequence 2,1,0 repeating.
REQ-033 Byte write byteen=4'b0010, wdata=32'hAAAA_AAAA to PRESET=32'h1234_5678 -> PRESET reads 32'h1234_AA78; write to COUNT -> unchanged.
REQ-034 Clear EN mid-count at COUNT=5 -> FSM IDLE, COUNT holds 5, no irq; reset==0 mid-count -> all registers 0, no irq.
REQ-035 Address 32'h7F0C or 32'h0000_0000 with byteen=4'hF -> no register change, rdata 0.
